// File: rtl/if_stage.sv
`timescale 1ns/1ps
// if_stage: instruction-fetch stage of the 5-stage MIPS32 pipeline.
// Owns the PC, the instruction-memory request handshake, a one-word hold
// buffer for words that arrive while ID is stalled, the IF/ID pipeline
// register and a saturating stall-cycle counter for performance debug.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        IFID_Write,
   input  logic        PCSrc,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_instr,
   output logic [31:0] IF_ID_PCplus4,
   output logic        IF_ID_valid,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetchStateT;

   // Sequential address of the next instruction; wraps modulo 2^32.
   function automatic logic [31:0] nextWordAddr(input logic [31:0] addr);
      nextWordAddr = addr + 32'd4;
   endfunction

   // Saturating increment used by the performance counter.
   function automatic logic [15:0] satIncr16(input logic [15:0] value);
      if (value == 16'hFFFF) begin
         satIncr16 = value;
      end else begin
         satIncr16 = value + 16'd1;
      end
   endfunction

   fetchStateT  state_r;
   logic        req_r;
   logic [31:0] pc_r;
   logic [31:0] ifidInstr_r;
   logic [31:0] ifidPcPlus4_r;
   logic        ifidValid_r;
   logic [31:0] holdInstr_r;
   logic [31:0] holdPcPlus4_r;
   logic [15:0] stallCount_r;

   logic        stall_s;
   logic        fetchDone_s;
   logic [31:0] pcPlus4_s;

   // Stall detection may drop either enable; treat either one low as a stall.
   assign stall_s     = !PCWrite || !IFID_Write;
   assign fetchDone_s = req_r && imem_ready;
   assign pcPlus4_s   = nextWordAddr(pc_r);

   // Memory-side outputs come straight from registers: no input-to-output path.
   assign imem_req      = req_r;
   assign imem_addr     = pc_r;
   assign PC            = pc_r;
   assign IF_ID_instr   = ifidInstr_r;
   assign IF_ID_PCplus4 = ifidPcPlus4_r;
   assign IF_ID_valid   = ifidValid_r;
   assign stall_cycles  = stallCount_r;

   // Fetch FSM, PC, hold buffer and IF/ID register; redirect beats stall beats fetch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         req_r         <= 1'b0;
         pc_r          <= RESET_PC;
         ifidInstr_r   <= 32'h0000_0000;
         ifidPcPlus4_r <= 32'h0000_0000;
         ifidValid_r   <= 1'b0;
         holdInstr_r   <= 32'h0000_0000;
         holdPcPlus4_r <= 32'h0000_0000;
      end else if (PCSrc) begin
         // Taken branch: drop whatever arrives now, flush IF/ID, restart fetch.
         state_r       <= FETCH;
         req_r         <= 1'b1;
         pc_r          <= branch_target;
         ifidInstr_r   <= 32'h0000_0000;
         ifidValid_r   <= 1'b0;
         holdInstr_r   <= 32'h0000_0000;
         holdPcPlus4_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               state_r <= FETCH;
               req_r   <= 1'b1;
            end
            FETCH: begin
               if (fetchDone_s && !stall_s) begin
                  ifidInstr_r   <= imem_rdata;
                  ifidPcPlus4_r <= pcPlus4_s;
                  ifidValid_r   <= 1'b1;
                  pc_r          <= pcPlus4_s;
                  state_r       <= FETCH;
                  req_r         <= 1'b1;
               end else if (fetchDone_s) begin
                  // Word arrived while ID is stalled: park it, stop requesting.
                  holdInstr_r   <= imem_rdata;
                  holdPcPlus4_r <= pcPlus4_s;
                  state_r       <= HOLD;
                  req_r         <= 1'b0;
               end else if (!stall_s) begin
                  // Memory not ready: push a bubble, keep PCplus4 as it was.
                  ifidInstr_r <= 32'h0000_0000;
                  ifidValid_r <= 1'b0;
                  state_r     <= FETCH;
                  req_r       <= 1'b1;
               end else begin
                  state_r <= FETCH;
                  req_r   <= 1'b1;
               end
            end
            HOLD: begin
               if (!stall_s) begin
                  // Buffered word enters IF/ID on the first unstalled edge.
                  ifidInstr_r   <= holdInstr_r;
                  ifidPcPlus4_r <= holdPcPlus4_r;
                  ifidValid_r   <= 1'b1;
                  pc_r          <= pcPlus4_s;
                  holdInstr_r   <= 32'h0000_0000;
                  holdPcPlus4_r <= 32'h0000_0000;
                  state_r       <= FETCH;
                  req_r         <= 1'b1;
               end else begin
                  state_r <= HOLD;
                  req_r   <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               req_r   <= 1'b0;
            end
         endcase
      end
   end

   // Performance counter: cycles with PCWrite low, including redirect cycles.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stallCount_r <= 16'h0000;
      end else if (!PCWrite) begin
         stallCount_r <= satIncr16(stallCount_r);
      end else begin
         stallCount_r <= stallCount_r;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Self-checking bench for if_stage: a queue-based fetch model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_if_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        PCWrite;
   logic        IFID_Write;
   logic        PCSrc;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] PC;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_PCplus4;
   logic        IF_ID_valid;
   logic [15:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   bit cmpOn  = 1'b0;

   // Model state: architectural view of the stage.
   logic [31:0] mPC;
   logic [31:0] mInstr;
   logic [31:0] mP4;
   logic        mValid;
   logic        mIdle;
   logic        mReq;
   logic [15:0] mStalls;
   logic [31:0] mBuf[$];

   always #5 clock = ~clock;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clock(clock), .reset(reset), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
      .PCSrc(PCSrc), .branch_target(branch_target), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .PC(PC), .IF_ID_instr(IF_ID_instr), .IF_ID_PCplus4(IF_ID_PCplus4),
      .IF_ID_valid(IF_ID_valid), .stall_cycles(stall_cycles)
   );

   // Instruction memory contents: address-dependent pattern.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      memWord = {~a[15:0], a[15:0]};
   endfunction

   assign imem_rdata = memWord(imem_addr);

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPC = 32'h0000_0000; mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0;
      mIdle = 1'b1; mReq = 1'b0; mStalls = 16'h0; mBuf.delete();
   endtask

   task automatic deliver(input logic [31:0] w);
      mInstr = w;
      mP4    = mPC + 32'd4;
      mValid = 1'b1;
      mPC    = mPC + 32'd4;
   endtask

   task automatic modelStep();
      logic stall;
      logic done;
      logic [31:0] w;
      stall = !PCWrite || !IFID_Write;
      done  = mReq && imem_ready;
      if (!PCWrite && mStalls != 16'hFFFF) mStalls = mStalls + 16'd1;
      if (PCSrc) begin
         mPC = branch_target; mInstr = 32'h0; mValid = 1'b0; mBuf.delete(); mIdle = 1'b0;
      end else if (mIdle) begin
         mIdle = 1'b0;
      end else if (mBuf.size() != 0) begin
         if (!stall) begin
            w = mBuf.pop_front();
            deliver(w);
         end
      end else if (done) begin
         if (stall) mBuf.push_back(memWord(mPC));
         else deliver(memWord(mPC));
      end else if (!stall) begin
         mInstr = 32'h0; mValid = 1'b0;
      end
      mReq = !mIdle && (mBuf.size() == 0);
   endtask

   // Model advances on each edge and resets asynchronously with the DUT.
   initial begin
      modelReset();
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) modelReset();
         else modelStep();
      end
   end

   // Every-cycle comparison on the inactive edge.
   initial begin
      forever begin
         @(negedge clock);
         if (cmpOn) begin
            chk1 ("m_req",   imem_req,      mReq);
            chk32("m_addr",  imem_addr,     mPC);
            chk32("m_pc",    PC,            mPC);
            chk32("m_instr", IF_ID_instr,   mInstr);
            chk32("m_p4",    IF_ID_PCplus4, mP4);
            chk1 ("m_valid", IF_ID_valid,   mValid);
            chk32("m_stall", 32'(stall_cycles), 32'(mStalls));
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; PCWrite = 1'b1; IFID_Write = 1'b1; PCSrc = 1'b0;
      branch_target = 32'h0; imem_ready = 1'b1;
      repeat (3) cyc();
      cmpOn = 1'b1;
      chk1 ("rst_req",   imem_req, 1'b0);
      chk32("rst_pc",    PC, 32'h0);
      chk1 ("rst_valid", IF_ID_valid, 1'b0);
      chk32("rst_stall", 32'(stall_cycles), 32'h0);

      // Straight-line fetch with memory always ready.
      reset = 1'b1;
      chk1 ("c0_req", imem_req, 1'b0);
      cyc();
      chk1 ("c1_req", imem_req, 1'b1);
      chk32("c1_addr", imem_addr, 32'h0);
      cyc();
      chk32("c2_addr", imem_addr, 32'h4);
      chk1 ("c2_valid", IF_ID_valid, 1'b1);
      chk32("c2_p4", IF_ID_PCplus4, 32'h4);
      chk32("c2_instr", IF_ID_instr, 32'hFFFF_0000);
      cyc();
      chk32("c3_addr", imem_addr, 32'h8);
      chk32("c3_p4", IF_ID_PCplus4, 32'h8);
      cyc();
      chk32("c4_p4", IF_ID_PCplus4, 32'hC);

      // Reset pulse, then memory not ready for two cycles at PC=4.
      reset = 1'b0;
      #1;
      chk32("rp_pc", PC, 32'h0);
      chk1 ("rp_req", imem_req, 1'b0);
      cyc();
      reset = 1'b1;
      cyc();
      cyc();
      imem_ready = 1'b0;
      cyc();
      chk1 ("nr1_valid", IF_ID_valid, 1'b0);
      chk32("nr1_pc", PC, 32'h4);
      cyc();
      chk1 ("nr2_valid", IF_ID_valid, 1'b0);
      chk32("nr2_pc", PC, 32'h4);
      imem_ready = 1'b1;
      cyc();
      chk32("nr_instr", IF_ID_instr, 32'hFFFB_0004);
      chk32("nr_p4", IF_ID_PCplus4, 32'h8);

      // Three stall cycles while the fetch at 8 completes.
      PCWrite = 1'b0; IFID_Write = 1'b0;
      cyc();
      cyc();
      cyc();
      chk1 ("hold_req", imem_req, 1'b0);
      chk32("hold_instr", IF_ID_instr, 32'hFFFB_0004);
      chk32("hold_stall", 32'(stall_cycles), 32'd3);
      PCWrite = 1'b1; IFID_Write = 1'b1;
      cyc();
      chk32("rel_instr", IF_ID_instr, 32'hFFF7_0008);
      chk32("rel_p4", IF_ID_PCplus4, 32'hC);
      chk32("rel_addr", imem_addr, 32'hC);

      // Redirect while a fetch completes.
      PCSrc = 1'b1; branch_target = 32'h40;
      cyc();
      chk1 ("br_valid", IF_ID_valid, 1'b0);
      chk32("br_instr", IF_ID_instr, 32'h0);
      chk32("br_addr", imem_addr, 32'h40);
      PCSrc = 1'b0;
      cyc();
      chk32("br_tgt_instr", IF_ID_instr, 32'hFFBF_0040);

      // Redirect in HOLD with stall active: buffered word is dropped.
      PCWrite = 1'b0; IFID_Write = 1'b0;
      cyc();
      chk1 ("h2_req", imem_req, 1'b0);
      PCSrc = 1'b1; branch_target = 32'h100;
      cyc();
      chk32("h2_pc", PC, 32'h100);
      chk1 ("h2_req2", imem_req, 1'b1);
      chk1 ("h2_valid", IF_ID_valid, 1'b0);
      chk32("h2_stall", 32'(stall_cycles), 32'd5);
      PCSrc = 1'b0; PCWrite = 1'b1; IFID_Write = 1'b1;
      cyc();
      chk32("h2_instr", IF_ID_instr, 32'hFEFF_0100);
      chk32("h2_p4", IF_ID_PCplus4, 32'h104);

      // PC+4 wraps at the top of the address space.
      PCSrc = 1'b1; branch_target = 32'hFFFF_FFFC;
      cyc();
      PCSrc = 1'b0;
      chk32("wr_addr", imem_addr, 32'hFFFF_FFFC);
      cyc();
      chk32("wr_instr", IF_ID_instr, 32'h0003_FFFC);
      chk32("wr_p4", IF_ID_PCplus4, 32'h0);
      chk32("wr_pc", PC, 32'h0);

      // Long stall with a pending request: counter saturates.
      imem_ready = 1'b0; PCWrite = 1'b0; IFID_Write = 1'b0;
      repeat (70000) cyc();
      chk32("sat_stall", 32'(stall_cycles), 32'h0000_FFFF);
      chk1 ("sat_req", imem_req, 1'b1);

      // Reset in the middle of the wait takes effect without a clock edge.
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      chk1 ("ar_req", imem_req, 1'b0);
      chk32("ar_pc", PC, 32'h0);
      chk32("ar_instr", IF_ID_instr, 32'h0);
      chk32("ar_p4", IF_ID_PCplus4, 32'h0);
      chk1 ("ar_valid", IF_ID_valid, 1'b0);
      chk32("ar_stall", 32'(stall_cycles), 32'h0);
      repeat (2) cyc();
      reset = 1'b1; imem_ready = 1'b1; PCWrite = 1'b1; IFID_Write = 1'b1;
      repeat (4) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS32 pipeline. It owns the PC register, the handshake with instruction memory, a one-word hold buffer and the IF/ID pipeline register. It sits directly upstream of ID, where main control and stall detection operate. It obeys the PCWrite/IFID_Write stall signals from stall detection and the taken-branch redirect (PCSrc/branch_target). It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- PCWrite  in  1  0 = hold PC (load-use stall from stall detection).
- IFID_Write  in  1  0 = hold IF/ID register.
- PCSrc  in  1  1 = taken branch; redirect fetch to branch_target.
- branch_target  in  32  redirect address, word aligned.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals PC.
- imem_ready  in  1  when high together with imem_req, imem_rdata is valid this cycle for imem_addr.
- imem_rdata  in  32  instruction word.
- PC  out  32  current PC.
- IF_ID_instr  out  32  instruction to ID.
- IF_ID_PCplus4  out  32  PC+4 of that instruction.
- IF_ID_valid  out  1  1 = IF/ID holds a real instruction.
- stall_cycles  out  16  count of cycles with PCWrite==0, saturating.

## Operation
- Stall condition: stall = !PCWrite || !IFID_Write. Stall detection drives both signals together; either one low is treated as a stall.
- Fetch completes in a cycle when imem_req && imem_ready.
- FSM states:
  - IDLE: imem_req=0; goes to FETCH unconditionally on the next cycle.
  - FETCH: imem_req=1.
  - HOLD: imem_req=0; holds a buffered word.
- Priority in every state: PCSrc > stall > fetch.
- PCSrc=1 in any state:
  - PC <= branch_target.
  - IF_ID_instr <= 0 (nop) and IF_ID_valid <= 0, regardless of IFID_Write.
  - Any word completing this cycle is discarded; the hold buffer is invalidated.
  - State goes to FETCH (from IDLE as well).
- FETCH, no PCSrc:
  - Fetch completes, no stall: IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4.
  - Fetch completes under stall: word goes to hold buffer with its PC+4; IF/ID and PC hold; state goes to HOLD.
  - No completion, no stall: IF/ID <= bubble (instr 0, valid 0, PCplus4 unchanged); PC holds.
  - No completion under stall: IF/ID and PC hold.
- HOLD, no PCSrc:
  - Stall: everything holds.
  - No stall: IF/ID <= buffer contents with valid=1; PC <= PC+4; state goes to FETCH.
- PC+4 arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- stall_cycles increments on every cycle with PCWrite==0, including during PCSrc. It saturates at 16'hFFFF.
- Reset values:
  - PC = RESET_PC.
  - IF_ID_instr = 0, IF_ID_PCplus4 = 0, IF_ID_valid = 0.
  - Hold buffer cleared; state = IDLE, so imem_req = 0.
  - stall_cycles = 0.
- Reset asserted mid-wait or in HOLD aborts the fetch immediately: imem_req drops asynchronously and the buffered word is lost.

## Timing
- All registers update on the rising clock edge. Reset is asynchronous on assertion and synchronous to the next edge on release.
- imem_req and imem_addr are functions of state and PC only (registered), with no combinational path from inputs.
- First request is in the second cycle after reset deasserts (one IDLE cycle).
- With imem_ready tied high and no stalls, throughput is one instruction per cycle and IF/ID is valid in the cycle after the address is presented.
- Redirect latency: request to branch_target is in the cycle after PCSrc; IF/ID shows a bubble in that same cycle.
- HOLD costs no extra cycle: the buffered word enters IF/ID on the first unstalled edge.
- imem_addr may change while a request is pending only on redirect. Memory must accept the abandoned request without side effects.

## Test plan
- Reset release, imem_ready=1, imem_rdata = address-dependent pattern:
  - Cycle 0: imem_req=0.
  - Then imem_addr = 0, 4, 8 on consecutive cycles.
  - IF/ID valid from cycle 2 with PCplus4 = 4, 8, 12.
- imem_ready low for 2 cycles at PC=4 → IF_ID_valid=0 for 2 cycles, PC stays 4, then instr@4 loads with PCplus4=8.
- PCWrite=IFID_Write=0 for 3 cycles while a fetch at 8 completes:
  - state HOLD, imem_req=0, IF/ID unchanged, stall_cycles=3.
  - On release, IF/ID = instr@8 with PCplus4=12; next request at 12.
- PCSrc=1 with branch_target=0x40 while a fetch completes → IF_ID_valid=0, IF_ID_instr=0; next cycle imem_addr=0x40.
- PCSrc=1 in HOLD with stall active simultaneously → buffer discarded, IF/ID flushed, PC=branch_target, state FETCH.
- Hold PCWrite=0 for 70000 cycles → stall_cycles stops at 16'hFFFF. Assert reset mid-wait → all outputs return to reset values asynchronously.
